oneshot_rr_sched: RTL and testbench

//   Round-robin scheduler sharing one single-shot responder (trigger in, ack out, sticky-armed)

---
 rtl/oneshot_sched_pkg.sv | 13 +
 rtl/rr_pick.sv | 30 +++
 rtl/oneshot_rr_sched.sv | 110 +++++++++++
 tb/tb_oneshot_rr_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oneshot_sched_pkg.sv
// Shared types and defaults for the round-robin single-shot responder scheduler.
package oneshot_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               vld_o,
  output logic [IDX_W-1:0]   winner_o
);

  always_comb begin : scan
    int               idx;
    logic [IDX_W-1:0] idx_w;
    vld_o    = 1'b0;
    winner_o = '0;
    idx      = 0;
    idx_w    = '0;
    // Offset NUM_REQ wraps back to ptr itself, so a lone requester is regranted.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(ptr_i) + i) % NUM_REQ;
      idx_w = IDX_W'(idx);
      if (!vld_o && req_i[idx_w]) begin
        vld_o    = 1'b1;
        winner_o = idx_w;
      end
    end
  end

endmodule

// File: rtl/oneshot_rr_sched.sv
// Shares one single-shot responder among NUM_REQ requesters: grant, trigger once,
// wait for ack or timeout, release, rotate priority.
module oneshot_rr_sched
  import oneshot_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               start,
  input  logic               ack,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               busy
);

  localparam int               IDX_W   = $clog2(NUM_REQ);
  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .vld_o    (pick_vld),
    .winner_o (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      winner_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    start    = 1'b0;
    done     = '0;
    err      = '0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          winner_d = pick_idx;
          gnt_d    = NUM_REQ'(1) << pick_idx;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        start   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // ack takes precedence over a timeout landing in the same cycle.
        if (ack) begin
          done    = gnt_q;
          state_d = RELEASE;
        end else if (cnt_q == CNT_MAX) begin
          err     = gnt_q;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        ptr_d   = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt = gnt_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_start_busy:  assert property (@(posedge clk) disable iff (!rst_n) start |=> busy);
  a_start_once:  assert property (@(posedge clk) disable iff (!rst_n) start |=> !start);
  a_done_err:    assert property (@(posedge clk) disable iff (!rst_n) (done & err) == '0);

endmodule

// File: tb/tb_oneshot_rr_sched.sv
// Scenario bench for oneshot_rr_sched: expected grants/outcomes queued at stimulus time.
module tb_oneshot_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       start;
  logic       ack;
  logic [3:0] done;
  logic [3:0] err;
  logic       busy;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] done;
    logic [3:0] err;
  } txn_t;

  txn_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  oneshot_rr_sched #(.NUM_REQ(4), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .start (start),
    .ack   (ack),
    .done  (done),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      #1;
      if (start) seen = 1'b1;
    end
  endtask

  function automatic txn_t pop_exp();
    txn_t t;
    t.gnt = 4'hx; t.done = 4'hx; t.err = 4'hx;
    if (sb_q.size() > 0) t = sb_q.pop_front();
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; ack = 1'b0;
    #1;
    total++;
    if ({gnt, start, busy, done, err} !== 15'd0) begin
      bad++; $display("FAIL reset_assert got=%h exp=0", {gnt, start, busy, done, err});
    end
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      total++;
      if ({gnt, start, busy, done, err} !== 15'd0) begin
        bad++; $display("FAIL reset_idle[%0d] got=%h exp=0", i, {gnt, start, busy, done, err});
      end
    end
  endtask

  task automatic test_rr();
    bit   seen;
    int   hold;
    txn_t e;
    for (int g = 0; g < 5; g++) begin
      txn_t t;
      t.gnt = 4'b0001 << (g % 4); t.done = t.gnt; t.err = 4'b0000;
      sb_q.push_back(t);
    end
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start(8, seen);
      total++;
      if (!seen) begin
        bad++; $display("FAIL rr_start[%0d] got=no_start exp=start", g);
        break;
      end
      e = pop_exp();
      total++;
      if (gnt !== e.gnt) begin
        bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", g, gnt, e.gnt);
      end
      hold = 1;
      step(); ack = 1'b1; #1;
      total++;
      if (done !== e.done || err !== e.err) begin
        bad++; $display("FAIL rr_done[%0d] got=%b/%b exp=%b/%b", g, done, err, e.done, e.err);
      end
      if (gnt !== 4'b0000) hold++;
      step(); ack = 1'b0; #1;
      if (gnt !== 4'b0000) hold++;
      step();
      if (g == 4) req = 4'b0000;
      #1;
      if (gnt !== 4'b0000) hold++;
      total++;
      if (hold != 3 || busy !== 1'b0) begin
        bad++; $display("FAIL rr_hold[%0d] got=%0d busy=%b exp=3 busy=0", g, hold, busy);
      end
    end
  endtask

  task automatic test_single();
    txn_t e;
    req = 4'b0100;
    sb_q.push_back('{gnt: 4'b0100, done: 4'b0100, err: 4'b0000});
    step(); ack = 1'b1; #1;
    total++;
    if (gnt !== 4'b0100 || start !== 1'b1 || done !== 4'b0000) begin
      bad++; $display("FAIL single_c1 got=gnt%b start%b done%b exp=gnt0100 start1 done0000", gnt, start, done);
    end
    step(); ack = 1'b0; #1;
    total++;
    if (start !== 1'b0 || busy !== 1'b1 || done !== 4'b0000 || err !== 4'b0000) begin
      bad++; $display("FAIL single_c2 got=start%b busy%b done%b err%b exp=0 1 0000 0000", start, busy, done, err);
    end
    step(); ack = 1'b1; #1;
    e = pop_exp();
    total++;
    if (done !== e.done || err !== e.err) begin
      bad++; $display("FAIL single_done got=%b/%b exp=%b/%b", done, err, e.done, e.err);
    end
    step(); ack = 1'b0; req = 4'b0000; #1;
    total++;
    if (gnt !== 4'b0100 || done !== 4'b0000) begin
      bad++; $display("FAIL single_release got=gnt%b done%b exp=gnt0100 done0000", gnt, done);
    end
    step(); #1;
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL single_idle got=gnt%b busy%b exp=gnt0000 busy0", gnt, busy);
    end
  endtask

  task automatic test_timeout();
    bit         seen;
    bit         done_seen;
    int         k;
    int         j;
    logic [3:0] errv;
    txn_t       e;
    req = 4'b0010;
    sb_q.push_back('{gnt: 4'b0010, done: 4'b0000, err: 4'b0010});
    sb_q.push_back('{gnt: 4'b0010, done: 4'b0010, err: 4'b0000});
    wait_start(4, seen);
    e = pop_exp();
    total++;
    if (!seen || gnt !== e.gnt) begin
      bad++; $display("FAIL to_gnt got=start%b gnt%b exp=start1 gnt%b", seen, gnt, e.gnt);
    end
    done_seen = 1'b0;
    errv = 4'b0000;
    for (k = 1; k <= 40; k++) begin
      step(); #1;
      if (done !== 4'b0000) done_seen = 1'b1;
      if (err !== 4'b0000) begin
        errv = err;
        break;
      end
    end
    total++;
    if (k != 15 || errv !== e.err) begin
      bad++; $display("FAIL to_err got=cycle%0d err%b exp=cycle15 err%b", k, errv, e.err);
    end
    total++;
    if (done_seen) begin
      bad++; $display("FAIL to_done_quiet got=done_pulse exp=no_done");
    end
    for (j = 1; j <= 8; j++) begin
      step(); #1;
      if (start) break;
    end
    e = pop_exp();
    total++;
    if (j != 3 || gnt !== e.gnt) begin
      bad++; $display("FAIL to_regrant got=delay%0d gnt%b exp=delay3 gnt%b", j, gnt, e.gnt);
    end
    step(); ack = 1'b1; #1;
    total++;
    if (done !== e.done || err !== e.err) begin
      bad++; $display("FAIL to_regrant_done got=%b/%b exp=%b/%b", done, err, e.done, e.err);
    end
    step(); ack = 1'b0; req = 4'b0000; #1;
    step(); #1;
  endtask

  task automatic test_coincide();
    bit   seen;
    bit   quiet;
    txn_t e;
    req = 4'b1000;
    sb_q.push_back('{gnt: 4'b1000, done: 4'b1000, err: 4'b0000});
    wait_start(4, seen);
    e = pop_exp();
    total++;
    if (!seen || gnt !== e.gnt) begin
      bad++; $display("FAIL co_gnt got=start%b gnt%b exp=start1 gnt%b", seen, gnt, e.gnt);
    end
    quiet = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(); ack = 1'b0; #1;
      if ((done | err) !== 4'b0000) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++; $display("FAIL co_quiet got=early_pulse exp=none");
    end
    step(); ack = 1'b1; #1;
    total++;
    if (done !== e.done) begin
      bad++; $display("FAIL co_done got=%b exp=%b", done, e.done);
    end
    total++;
    if (err !== e.err) begin
      bad++; $display("FAIL co_err got=%b exp=%b", err, e.err);
    end
    step(); ack = 1'b0; req = 4'b0000; #1;
    step(); #1;
  endtask

  task automatic test_reset_mid();
    bit   seen;
    txn_t e;
    req = 4'b1000;
    wait_start(4, seen);
    step(); #1;
    total++;
    if (!seen || gnt !== 4'b1000 || busy !== 1'b1) begin
      bad++; $display("FAIL rm_wait got=start%b gnt%b busy%b exp=1 1000 1", seen, gnt, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt, start, busy, done, err} !== 15'd0) begin
      bad++; $display("FAIL rm_async got=%h exp=0", {gnt, start, busy, done, err});
    end
    step(); step();
    req = 4'b1001;
    rst_n = 1'b1;
    sb_q.push_back('{gnt: 4'b0001, done: 4'b0001, err: 4'b0000});
    wait_start(4, seen);
    e = pop_exp();
    total++;
    if (!seen || gnt !== e.gnt) begin
      bad++; $display("FAIL rm_first got=start%b gnt%b exp=start1 gnt%b", seen, gnt, e.gnt);
    end
    step(); ack = 1'b1; #1;
    total++;
    if (done !== e.done || err !== e.err) begin
      bad++; $display("FAIL rm_done got=%b/%b exp=%b/%b", done, err, e.done, e.err);
    end
    step(); ack = 1'b0; req = 4'b0000; #1;
    step(); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr();
    test_single();
    test_timeout();
    test_coincide();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
